// File: rtl/spike_time_decoder.sv
// spike_time_decoder: temporal-code receiver for one decode window.
//
// Over one PERIOD-step window this block steps the shared time counter. It
// records the first step at which each spike line goes high, and reports the
// earliest-firing channel. Results hold between windows until the next start
// is accepted.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        single-cycle request to begin a window (accepted in IDLE/DONE)
//   spike_in     per-channel spike level, sampled every RUN cycle
//   time_val     current time step, fed back to the spike generators
//   busy         high while a window is running
//   done         one-cycle pulse at window completion
//   fired        per-channel "spike seen" flag
//   spike_time   per-channel first-spike step, lane i at [i*TW +: TW]
//   winner       lowest-index channel among the earliest spikes
//   winner_valid at least one channel fired, winner meaningful
module spike_time_decoder #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned PERIOD = 8,
  parameter int unsigned TW     = 4,
  localparam int unsigned WW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CH-1:0]    spike_in,
  output logic [TW-1:0]        time_val,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_CH-1:0]    fired,
  output logic [NUM_CH*TW-1:0] spike_time,
  output logic [WW-1:0]        winner,
  output logic                 winner_valid
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [TW-1:0] LastStep = TW'(PERIOD - 1);
  localparam logic [TW-1:0] NoSpike  = TW'(PERIOD);

  state_e                 state_q, state_d;
  logic [TW-1:0]          time_q, time_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [NUM_CH-1:0]      fired_q, fired_d;
  logic [NUM_CH*TW-1:0]   lanes_q, lanes_d;
  logic [WW-1:0]          winner_q, winner_d;
  logic                   wv_q, wv_d;

  logic [NUM_CH-1:0]      new_hits;
  logic [WW-1:0]          first_hit;
  logic                   accept;

  // Only channels that have not fired yet can register a spike.
  always_comb begin
    new_hits  = spike_in & ~fired_q;
    first_hit = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (new_hits[i]) first_hit = WW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    fired_d  = fired_q;
    lanes_d  = lanes_q;
    winner_d = winner_q;
    wv_d     = wv_q;
    accept   = 1'b0;

    unique case (state_q)
      StIdle: begin
        time_d = '0;
        accept = start;
      end
      StRun: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (new_hits[i]) lanes_d[i*TW +: TW] = time_q;
        end
        fired_d = fired_q | new_hits;
        if (!wv_q && (|new_hits)) begin
          winner_d = first_hit;
          wv_d     = 1'b1;
        end
        if (time_q == LastStep) begin
          state_d = StDone;
          time_d  = '0;
        end else begin
          time_d = time_q + TW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        accept  = start;
      end
      default: state_d = StIdle;
    endcase

    // Starting a window wipes the previous results.
    if (accept) begin
      state_d  = StRun;
      time_d   = '0;
      fired_d  = '0;
      lanes_d  = {NUM_CH{NoSpike}};
      winner_d = '0;
      wv_d     = 1'b0;
    end

    busy_d = (state_d == StRun);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      time_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fired_q  <= '0;
      lanes_q  <= '0;
      winner_q <= '0;
      wv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      time_q   <= time_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fired_q  <= fired_d;
      lanes_q  <= lanes_d;
      winner_q <= winner_d;
      wv_q     <= wv_d;
    end
  end

  assign time_val     = time_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fired        = fired_q;
  assign spike_time   = lanes_q;
  assign winner       = winner_q;
  assign winner_valid = wv_q;

endmodule

// File: tb/tb_spike_time_decoder.sv
// Scoreboard bench for spike_time_decoder: the stimulus side pushes expected
// window results, and a negedge monitor pops and compares them on each done.
module tb_spike_time_decoder;

  localparam int NUM_CH = 8;
  localparam int PERIOD = 8;
  localparam int TW     = 4;
  localparam int WW     = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NUM_CH-1:0]    spike_in;
  logic [TW-1:0]        time_val;
  logic                 busy;
  logic                 done;
  logic [NUM_CH-1:0]    fired;
  logic [NUM_CH*TW-1:0] spike_time;
  logic [WW-1:0]        winner;
  logic                 winner_valid;

  spike_time_decoder #(
    .NUM_CH(NUM_CH),
    .PERIOD(PERIOD),
    .TW    (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .spike_in    (spike_in),
    .time_val    (time_val),
    .busy        (busy),
    .done        (done),
    .fired       (fired),
    .spike_time  (spike_time),
    .winner      (winner),
    .winner_valid(winner_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct packed {
    logic [NUM_CH*TW-1:0] lanes;
    logic [NUM_CH-1:0]    fired;
    logic [WW-1:0]        win;
    logic                 wv;
    int                   done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  bit   have_last = 1'b0;

  int checks = 0;
  int errors = 0;

  // Current window's generator program.
  int fs[NUM_CH];
  bit en[NUM_CH];
  int mode;  // after first spike: 0 pulse only, 1 hold high, 2 random chatter

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected results straight from the first-spike rules.
  function automatic exp_t model();
    exp_t e;
    int   best;
    e.lanes    = '0;
    e.fired    = '0;
    e.win      = '0;
    e.wv       = 1'b0;
    e.done_cyc = 0;
    best       = PERIOD;
    for (int i = 0; i < NUM_CH; i++) begin
      e.lanes[i*TW +: TW] = en[i] ? TW'(fs[i]) : TW'(PERIOD);
      e.fired[i]          = en[i];
      if (en[i] && fs[i] < best) begin
        best  = fs[i];
        e.win = WW'(i);
        e.wv  = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic drive_spikes(input int t);
    for (int i = 0; i < NUM_CH; i++) begin
      spike_in[i] = en[i] && (t == fs[i] ||
                    (t > fs[i] && (mode == 1 || (mode == 2 && $urandom_range(0, 1) == 1))));
    end
  endtask

  task automatic randomize_gen();
    for (int i = 0; i < NUM_CH; i++) begin
      en[i] = ($urandom_range(0, 3) != 0);
      fs[i] = $urandom_range(0, PERIOD - 1);
    end
    mode = $urandom_range(0, 2);
  endtask

  // Runs one window. Returns at #1 into the DONE cycle with start = chain.
  task automatic window(input bit pre_started, input bit mid_start, input bit chain);
    exp_t e;
    if (!pre_started) begin
      @(posedge clk); #1;
      start    = 1'b1;
      spike_in = NUM_CH'($urandom);
    end
    e          = model();
    e.done_cyc = cyc + 1 + PERIOD;
    sb.push_back(e);
    for (int t = 0; t < PERIOD; t++) begin
      @(posedge clk); #1;
      start = mid_start && (t == 3);
      drive_spikes(t);
    end
    @(posedge clk); #1;
    start    = chain;
    spike_in = NUM_CH'($urandom);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_done"}, 64'(done), 64'(0));
    check({tag, "_time"}, 64'(time_val), 64'(0));
    check({tag, "_fired"}, 64'(fired), 64'(0));
    check({tag, "_lanes"}, 64'(spike_time), 64'(0));
    check({tag, "_winner"}, 64'(winner), 64'(0));
    check({tag, "_wv"}, 64'(winner_valid), 64'(0));
  endtask

  // Monitor: compare at each done, and verify results hold while idle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      have_last = 1'b0;
    end else if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no window (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        check("done_cycle", 64'(cyc), 64'(e.done_cyc));
        check("busy_at_done", 64'(busy), 64'(0));
        check("time_at_done", 64'(time_val), 64'(0));
        check("spike_time", 64'(spike_time), 64'(e.lanes));
        check("fired", 64'(fired), 64'(e.fired));
        check("winner", 64'(winner), 64'(e.win));
        check("winner_valid", 64'(winner_valid), 64'(e.wv));
        last      = e;
        have_last = 1'b1;
      end
    end else if (!busy && have_last) begin
      check("hold_spike_time", 64'(spike_time), 64'(last.lanes));
      check("hold_fired", 64'(fired), 64'(last.fired));
      check("hold_winner", 64'({winner_valid, winner}), 64'({last.wv, last.win}));
    end
  end

  initial begin
    bit chain;
    bit prev;
    rst      = 1'b1;
    start    = 1'b0;
    spike_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    // Idle with line noise: nothing may change, done must not pulse.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      spike_in = NUM_CH'($urandom);
    end
    check_reset("idle");

    // Directed pattern: steps 3,0,7,5,none,2,2,6.
    fs   = '{3, 0, 7, 5, 0, 2, 2, 6};
    en   = '{1, 1, 1, 1, 0, 1, 1, 1};
    mode = 0;
    window(1'b0, 1'b0, 1'b0);

    // Tie at step 4 on ch2/ch5 with lines held high afterwards.
    en   = '{0, 0, 1, 0, 0, 1, 0, 0};
    fs   = '{0, 0, 4, 0, 0, 4, 0, 0};
    mode = 1;
    window(1'b0, 1'b0, 1'b0);

    // No spikes; start at step 3 ignored; start in DONE chains a new window.
    en = '{0, 0, 0, 0, 0, 0, 0, 0};
    window(1'b0, 1'b1, 1'b1);
    randomize_gen();
    window(1'b1, 1'b0, 1'b0);

    // Reset at step 5 of a window.
    randomize_gen();
    mode = 1;
    @(posedge clk); #1;
    start = 1'b1;
    for (int t = 0; t <= 5; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      drive_spikes(t);
      if (t == 5) rst = 1'b1;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset("mid_rst");
    randomize_gen();
    window(1'b0, 1'b0, 1'b0);

    // Random windows, random chaining and stray starts.
    prev = 1'b0;
    for (int n = 0; n < 30; n++) begin
      randomize_gen();
      chain = (n != 29) && ($urandom_range(0, 1) == 1);
      window(prev, ($urandom_range(0, 1) == 1), chain);
      prev = chain;
    end

    // Allow the final done to be consumed, bounded.
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d windows without done expected 0", sb.size());
    end
    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_time_decoder.md
# spike_time_decoder

Clocked temporal-code decoder at the receive end of the spike train produced by the spike generation stage. Over one PERIOD-step window it drives the shared time step, watches NUM_CH spike lines, and records the first step at which each line spikes. It also reports the earliest-firing channel for winner-take-all and STDP update logic. Results are held stable between windows.

## Interface
- NUM_CH, default 8: number of spike channels decoded.
- PERIOD, default 8: time steps per window (valid steps 0..PERIOD-1); must be >= 2.
- TW, default 4: width of time values; must satisfy 2^TW > PERIOD so PERIOD itself is encodable.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a decode window.
- spike_in  input  NUM_CH  spike level per channel; sampled every RUN cycle.
- time_val  output  TW  current time step; fed back to spike generators.
- busy  output  1  high while a window is in progress (RUN).
- done  output  1  one-cycle pulse when a window completes.
- fired  output  NUM_CH  per-channel flag: spike seen in last/current window.
- spike_time  output  NUM_CH*TW  per-channel first-spike step, channel i at bits [i*TW +: TW].
- winner  output  clog2(NUM_CH) (min 1)  index of earliest-firing channel.
- winner_valid  output  1  at least one channel fired; winner meaningful.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: time_val = 0, busy = 0. start=1 -> RUN next cycle; on that same edge fired cleared to 0, every spike_time lane loaded with PERIOD ("no spike"), winner = 0, winner_valid = 0, time_val = 0.
- RUN: busy = 1. Each cycle with time_val = t, for each channel i with fired[i]=0 and spike_in[i]=1: spike_time lane i <- t, fired[i] <- 1. Channels already fired ignore spike_in (first spike only; later high or toggling levels have no effect).
- Winner: on the first RUN cycle where any unfired channel spikes while winner_valid=0, winner <- lowest index among channels spiking that cycle, winner_valid <- 1. Never updated again in the window.
- Step advance: t < PERIOD-1 -> time_val <- t+1. At t = PERIOD-1 the sample is taken as normal, then -> DONE, time_val <- 0.
- DONE: lasts exactly one cycle, done = 1, busy = 0. Next state IDLE unless start=1, which restarts (same clearing as IDLE->RUN).
- start during RUN is ignored; the window is not extended or restarted.
- Channels never spiking keep spike_time = PERIOD, fired = 0.
- fired, spike_time, winner, winner_valid hold their values through DONE and IDLE until the next start is accepted.
- No arithmetic beyond the TW-bit step counter, which never wraps (stops at PERIOD-1).

## Timing
- Reset (rst=1 at an edge, any state including mid-RUN): state IDLE, time_val 0, busy 0, done 0, fired 0, all spike_time lanes 0, winner 0, winner_valid 0. rst overrides start in the same cycle.
- start accepted at edge k -> busy=1, time_val=0 from k; time_val=t during cycle k+t; done=1 during cycle k+PERIOD; busy=0 in that cycle.
- Window length exactly PERIOD RUN cycles; start-to-done latency PERIOD cycles; back-to-back windows via start in DONE give PERIOD+1 cycle cadence.
- spike_in is combinationally a function of time_val at the generator; it is sampled on the edge ending the cycle in which time_val=t, and the capture is visible from the next cycle.
- All outputs registered; no combinational path spike_in -> outputs.

## Test plan
- Reset then idle: rst 1 cycle, start=0 for 10 cycles -> all outputs 0, spike_time all 0, done never pulses.
- Single window, NUM_CH=8, PERIOD=8, generators programmed for ch0..7 firing at steps 3,0,7,5,(none),2,2,6 -> after done: spike_time = 3,0,7,5,8,2,2,6; fired = 0b11101111; winner=1, winner_valid=1; done exactly 8 cycles after start.
- Tie and persistence: ch2 and ch5 both first spike at step 4, spike_in held high to step 7 -> both lanes = 4, winner=2; no re-capture.
- No spikes: spike_in=0 whole window -> all lanes = 8, fired=0, winner_valid=0, done pulses normally.
- start during RUN at step 3 -> ignored, done still at cycle 8; start asserted during DONE -> new window begins next cycle with results cleared to PERIOD.
- rst at step 5 mid-window -> next cycle IDLE, all outputs at reset values; subsequent start runs a clean full window.
